// File: rtl/tone_pkg.sv
// Shared definitions for the DDS tone channel: waveform encodings and default widths.
// Imported by the synth core, its shaper and the benches that compute phase increments.
package tone_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'd0,
    MODE_SAW    = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_MUTE   = 2'd3
  } mode_e;

  localparam int ACC_W_DEF = 24;
  localparam int OUT_W_DEF = 8;

  // Output frequency = CLK_HZ * PHASE_INC / 2^ACC_W.
  localparam int CLK_HZ = 25_000_000;

endpackage

// File: rtl/tone_shape.sv
// Combinational waveform shaper: phase index + mode -> sample, then volume scaling.
// Zero latency, no backpressure; shared with the mixer bench.
module tone_shape
  import tone_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [1:0]       mode_i,
  input  logic [OUT_W-1:0] phase_i,
  input  logic [OUT_W-1:0] vol_i,
  output logic [OUT_W-1:0] sample_o
);

  logic [OUT_W-1:0]   tri_t;
  logic [OUT_W-1:0]   wave;
  logic [OUT_W:0]     vol_p1;
  logic [2*OUT_W:0]   product;

  always_comb begin
    tri_t = {phase_i[OUT_W-2:0], 1'b0};
    wave  = '0;
    case (mode_e'(mode_i))
      MODE_SQUARE: wave = phase_i[OUT_W-1] ? {OUT_W{1'b1}} : '0;
      MODE_SAW:    wave = phase_i;
      MODE_TRI:    wave = phase_i[OUT_W-1] ? ~tri_t : tri_t;
      default:     wave = '0;
    endcase

    // vol+1 makes all-ones an exact unity gain and zero a hard mute.
    vol_p1   = {1'b0, vol_i} + {{OUT_W{1'b0}}, 1'b1};
    product  = {{(OUT_W+1){1'b0}}, wave} * {{OUT_W{1'b0}}, vol_p1};
    sample_o = product[2*OUT_W-1:OUT_W];
  end

endmodule

// File: rtl/tone_synth.sv
// DDS tone channel: phase accumulator, period-aligned config shadowing, registered sample.
// One cycle from accumulator to OUT; no backpressure (free-running sample stream).
module tone_synth
  import tone_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [1:0]       MODE,
  input  logic [ACC_W-1:0] PHASE_INC,
  input  logic [OUT_W-1:0] VOLUME,
  output logic [OUT_W-1:0] OUT,
  output logic             WRAP
);

  if (OUT_W < 2 || ACC_W < OUT_W) begin : g_bad_params
    $error("tone_synth: requires OUT_W >= 2 and ACC_W >= OUT_W");
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  mode_e            mode_q, mode_d;
  logic [OUT_W-1:0] vol_q, vol_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic             load_cfg;
  logic [OUT_W-1:0] phase;
  logic [OUT_W-1:0] shaped;

  assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
  assign carry = sum[ACC_W];
  assign phase = acc_q[ACC_W-1 -: OUT_W];

  // Config only moves at a period boundary, when idle, or when frozen at inc=0,
  // so a running tone never emits a partial period.
  assign load_cfg = !ENABLE || (inc_q == '0) || carry;

  tone_shape #(
    .OUT_W (OUT_W)
  ) u_shape (
    .mode_i   (mode_q),
    .phase_i  (phase),
    .vol_i    (vol_q),
    .sample_o (shaped)
  );

  always_comb begin
    acc_d  = acc_q;
    inc_d  = inc_q;
    mode_d = mode_q;
    vol_d  = vol_q;
    out_d  = out_q;
    wrap_d = wrap_q;

    if (ENABLE) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = carry;
      out_d  = shaped;
    end else begin
      acc_d  = '0;
      wrap_d = 1'b0;
      out_d  = '0;
    end

    if (load_cfg) begin
      mode_d = mode_e'(MODE);
      inc_d  = PHASE_INC;
      vol_d  = VOLUME;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_q  <= '0;
      inc_q  <= '0;
      mode_q <= MODE_SQUARE;
      vol_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      mode_q <= mode_d;
      vol_q  <= vol_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign OUT  = out_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed waveform sequences plus randomized run against a phase model.
module tb_tone_synth;
  import tone_pkg::*;

  localparam int AW = 24;
  localparam int OW = 8;
  localparam longint MOD = 64'd1 << AW;

  logic          CLOCK = 1'b0;
  logic          RESET_N;
  logic          ENABLE;
  logic [1:0]    MODE;
  logic [AW-1:0] PHASE_INC;
  logic [OW-1:0] VOLUME;
  logic [OW-1:0] OUT;
  logic          WRAP;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: phase as an integer, active config, and the expected outputs.
  longint m_acc, m_inc;
  int     m_mode, m_vol, m_out;
  bit     m_wrap;

  tone_synth #(.ACC_W(AW), .OUT_W(OW)) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .ENABLE    (ENABLE),
    .MODE      (MODE),
    .PHASE_INC (PHASE_INC),
    .VOLUME    (VOLUME),
    .OUT       (OUT),
    .WRAP      (WRAP)
  );

  always #20 CLOCK = ~CLOCK;

  function automatic int ref_sample(int mode, int p, int vol);
    int w;
    case (mode)
      0:       w = (p >= 128) ? 255 : 0;
      1:       w = p;
      2:       w = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: w = 0;
    endcase
    return (w * (vol + 1)) / 256;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_inc = 0; m_mode = 0; m_vol = 0; m_out = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    longint nxt;
    bit     load;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    if (ENABLE) begin
      m_out  = ref_sample(m_mode, int'(m_acc >> (AW - OW)), m_vol);
      nxt    = m_acc + m_inc;
      m_wrap = (nxt >= MOD);
      load   = (m_inc == 0) || m_wrap;
      m_acc  = nxt % MOD;
    end else begin
      m_acc = 0; m_out = 0; m_wrap = 0;
      load  = 1;
    end
    if (load) begin
      m_mode = int'(MODE);
      m_inc  = longint'(PHASE_INC);
      m_vol  = int'(VOLUME);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    #1;
  endtask

  // Park the channel disabled for one edge so the new config is active and phase is zero.
  task automatic restart(input int mode, input int inc, input int vol);
    ENABLE    = 1'b0;
    MODE      = 2'(mode);
    PHASE_INC = AW'(inc);
    VOLUME    = OW'(vol);
    tick();
    ENABLE    = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ENABLE = 1'b0; MODE = 2'd0; PHASE_INC = '0; VOLUME = '0;
    model_reset();
    repeat (3) begin
      tick();
      n_checks++;
      if (OUT !== 8'd0 || WRAP !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold: OUT=%0d WRAP=%0b expected 0/0", OUT, WRAP);
      end
    end
    RESET_N = 1'b1;
    MODE = 2'd1; PHASE_INC = 24'h100000; VOLUME = 8'hFF;
    repeat (4) begin
      tick();
      n_checks++;
      if (OUT !== 8'd0 || WRAP !== 1'b0) begin
        n_fail++; $display("FAIL idle_disabled: OUT=%0d WRAP=%0b expected 0/0", OUT, WRAP);
      end
    end
  endtask

  task automatic test_square();
    int e;
    restart(0, 24'h100000, 8'hFF);
    for (int k = 1; k <= 48; k++) begin
      tick();
      e = (((k - 1) % 16) < 8) ? 0 : 255;
      n_checks++;
      if (OUT !== 8'(e) || WRAP !== (k % 16 == 0)) begin
        n_fail++; $display("FAIL square k=%0d: OUT=%0d WRAP=%0b expected %0d/%0b", k, OUT, WRAP, e, k % 16 == 0);
      end
    end
  endtask

  task automatic test_saw_tri();
    int e, p;
    restart(1, 24'h100000, 8'hFF);
    for (int k = 1; k <= 32; k++) begin
      tick();
      e = 16 * ((k - 1) % 16);
      n_checks++;
      if (OUT !== 8'(e) || WRAP !== (k % 16 == 0)) begin
        n_fail++; $display("FAIL saw k=%0d: OUT=%0d WRAP=%0b expected %0d/%0b", k, OUT, WRAP, e, k % 16 == 0);
      end
    end
    restart(2, 24'h100000, 8'hFF);
    for (int k = 1; k <= 32; k++) begin
      tick();
      p = 16 * ((k - 1) % 16);
      e = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      n_checks++;
      if (OUT !== 8'(e)) begin
        n_fail++; $display("FAIL triangle k=%0d: OUT=%0d expected %0d", k, OUT, e);
      end
    end
  endtask

  task automatic test_volume();
    int e;
    restart(0, 24'h100000, 8'h7F);
    for (int k = 1; k <= 32; k++) begin
      tick();
      e = (((k - 1) % 16) < 8) ? 0 : 127;
      n_checks++;
      if (OUT !== 8'(e)) begin
        n_fail++; $display("FAIL vol_half k=%0d: OUT=%0d expected %0d", k, OUT, e);
      end
    end
    restart(0, 24'h100000, 8'h00);
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_checks++;
      if (OUT !== 8'd0) begin
        n_fail++; $display("FAIL vol_zero k=%0d: OUT=%0d expected 0", k, OUT);
      end
    end
  endtask

  task automatic test_glitch_free();
    int e, j;
    bit w;
    restart(0, 24'h100000, 8'hFF);
    for (int k = 1; k <= 32; k++) begin
      if (k == 6) begin
        MODE = 2'd1; PHASE_INC = 24'h200000;
      end
      tick();
      if (k <= 16) begin
        e = (((k - 1) % 16) < 8) ? 0 : 255;
        w = (k == 16);
      end else begin
        j = k - 17;
        e = 32 * (j % 8);
        w = (j % 8 == 7);
      end
      n_checks++;
      if (OUT !== 8'(e) || WRAP !== w) begin
        n_fail++; $display("FAIL glitch_free k=%0d: OUT=%0d WRAP=%0b expected %0d/%0b", k, OUT, WRAP, e, w);
      end
    end
  endtask

  task automatic test_max_inc();
    restart(0, 24'h800000, 8'hFF);
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++;
      if (OUT !== ((k % 2 == 0) ? 8'd255 : 8'd0) || WRAP !== (k % 2 == 0)) begin
        n_fail++; $display("FAIL max_inc k=%0d: OUT=%0d WRAP=%0b expected %0d/%0b", k, OUT, WRAP, (k % 2 == 0) ? 255 : 0, k % 2 == 0);
      end
    end
  endtask

  task automatic test_enable_on_wrap();
    restart(0, 24'h600000, 8'hFF);
    tick();
    tick();
    ENABLE = 1'b0;
    tick();
    n_checks++;
    if (OUT !== 8'd0 || WRAP !== 1'b0) begin
      n_fail++; $display("FAIL drop_on_wrap: OUT=%0d WRAP=%0b expected 0/0", OUT, WRAP);
    end
    ENABLE = 1'b1;
    tick();
    n_checks++;
    if (OUT !== 8'd0 || WRAP !== 1'b0) begin
      n_fail++; $display("FAIL resume_phase0: OUT=%0d WRAP=%0b expected 0/0", OUT, WRAP);
    end
    tick();
    tick();
    n_checks++;
    if (OUT !== 8'd255 || WRAP !== 1'b1) begin
      n_fail++; $display("FAIL resume_wrap: OUT=%0d WRAP=%0b expected 255/1", OUT, WRAP);
    end
  endtask

  task automatic test_reset_midrun();
    restart(0, 24'h100000, 8'hFF);
    repeat (12) tick();
    n_checks++;
    if (OUT !== 8'd255) begin
      n_fail++; $display("FAIL pre_reset_high: OUT=%0d expected 255", OUT);
    end
    #5;
    RESET_N = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (OUT !== 8'd0 || WRAP !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: OUT=%0d WRAP=%0b expected 0/0", OUT, WRAP);
    end
    #4;
    RESET_N = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      n_checks++;
      if (OUT !== 8'(m_out) || WRAP !== m_wrap) begin
        n_fail++; $display("FAIL post_reset k=%0d: OUT=%0d WRAP=%0b expected %0d/%0b", k, OUT, WRAP, m_out, m_wrap);
      end
    end
  endtask

  task automatic test_random();
    int sel;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        MODE   = 2'($urandom_range(0, 3));
        VOLUME = 8'($urandom_range(0, 255));
        ENABLE = ($urandom_range(0, 15) != 0);
        sel    = int'($urandom_range(0, 9));
        if (sel == 0)      PHASE_INC = '0;
        else if (sel == 1) PHASE_INC = 24'h800000;
        else               PHASE_INC = 24'($urandom_range(1, 24'h300000));
      end
      tick();
      n_checks++;
      if (OUT !== 8'(m_out) || WRAP !== m_wrap) begin
        n_fail++; $display("FAIL random k=%0d: OUT=%0d WRAP=%0b expected %0d/%0b", k, OUT, WRAP, m_out, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_saw_tri();
    test_volume();
    test_glitch_free();
    test_max_inc();
    test_enable_on_wrap();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Parametrised successor to the 25 MHz single-channel square-wave audio generator.
- Phase-accumulator (DDS) tone source with selectable waveform (square, sawtooth, triangle, silence), digital volume, and glitch-free parameter update at period boundaries.
- Feeds the audio DAC output path; one instance per tone channel.
- Downstream mixers sum several instances.

Parameters:
- ACC_W, 24, phase accumulator width. Output frequency = Fclk * PHASE_INC / 2^ACC_W.
- OUT_W, 8, sample width on OUT and VOLUME. Must satisfy OUT_W >= 2 and ACC_W >= OUT_W.

Ports:
- CLOCK  input  1  system clock (25 MHz).
- RESET_N  input  1  asynchronous, active-low reset.
- ENABLE  input  1  1 = run; 0 = hold silent and phase at zero.
- MODE  input  2  waveform select: 0 square, 1 sawtooth, 2 triangle, 3 silence.
- PHASE_INC  input  ACC_W  phase increment per clock.
- VOLUME  input  OUT_W  amplitude scale; all-ones = full scale.
- OUT  output  OUT_W  unsigned sample, registered.
- WRAP  output  1  one-cycle pulse when the accumulator wraps (period boundary).

Behaviour:
- Reset (RESET_N low, asynchronous): acc=0, active config (mode=0, inc=0, vol=0), OUT=0, WRAP=0. Takes effect immediately, even mid-period. First update occurs on the first CLOCK edge after release.
- Active config registers: MODE/PHASE_INC/VOLUME are copied into active registers on any edge where ENABLE=0, or active inc==0, or the accumulator carries out on that edge.
- Config inputs are ignored at all other times. A mid-period change therefore applies from the first sample after WRAP, with no partial periods.
- ENABLE=1: {carry, acc} <= acc + inc_active (ACC_W+1-bit add, modulo 2^ACC_W). WRAP <= carry.
- ENABLE=0: acc <= 0, WRAP <= 0, OUT <= 0.
- Phase index p = acc[ACC_W-1 -: OUT_W], taken from the pre-update acc value.
- Waveform w(p), OUT_W bits:
  - square: p MSB=0 -> 0; MSB=1 -> all ones. Low half comes first, matching the legacy generator.
  - sawtooth: w = p.
  - triangle: t = {p[OUT_W-2:0],1'b0}; MSB=0 -> t; MSB=1 -> ~t.
  - silence: w = 0.
- Scaling: OUT <= (w * (vol_active+1)) >> OUT_W, computed with a 2*OUT_W+1-bit product.
  - vol=all ones gives OUT=w exactly.
  - vol=0 gives 0 for all w.
- Latency: OUT at edge k+1 reflects acc after edge k (one register stage). WRAP is asserted on the same edge the acc carries.
- inc=0 with ENABLE=1: acc frozen, OUT constant at w(p) of the frozen phase (0 after reset). Config loads every cycle in this state.
- Maximum inc: inc=2^(ACC_W-1) gives a square wave toggling every cycle and WRAP every 2nd cycle. inc>2^(ACC_W-1) aliases; no check is performed.
- Simultaneous ENABLE falling and carry: ENABLE=0 wins (acc=0, WRAP=0).

Decomposition:
- Shared package tone_pkg holds:
  - MODE encodings: MODE_SQUARE=0, MODE_SAW=1, MODE_TRI=2, MODE_MUTE=3.
  - Default ACC_W/OUT_W.
  - Helper constant CLK_HZ=25_000_000 for increment computation in benches and top level.
- One combinational sub-module, tone_shape: (mode, p, vol) -> scaled sample. It is reused by the mixer bench.
- Accumulator, config shadowing and output register stay in tone_synth.

Test Plan:
- Reset/idle: RESET_N low for 3 cycles, then high with ENABLE=0 -> OUT=0, WRAP=0 every cycle. Assert RESET_N low mid-run -> OUT=0 immediately, without waiting for a clock edge.
- Square: MODE=0, inc=0x100000, VOL=0xFF, ENABLE=1 -> 16-cycle period: 8 samples of 0, then 8 of 255; WRAP every 16th cycle.
- Saw/triangle: inc=0x100000.
  - MODE=1 -> 0,16,32,...,240 repeating.
  - MODE=2 -> 0,32,...,224,255,223,...,31 repeating.
- Volume: MODE=0, VOL=0x7F -> high level 127. VOL=0x00 -> all samples 0.
- Glitch-free update: mid-period, switch MODE 0->1 and inc to 0x200000 -> the square period completes unchanged; after WRAP the output becomes a saw with step 32 and an 8-cycle period.
- Edge cases:
  - inc=0x800000, MODE=0 -> OUT alternates 0/255 each cycle, WRAP every 2nd cycle.
  - ENABLE dropped on a wrap cycle -> WRAP=0 and acc=0.
